// File: rtl/structs.sv
// Shared codebase structs: the predictor_update stream type and the branch
// update sequencer slot state. The package widths match the sequencer's
// default parameters; an instance with other PC_BITS/ROB_INDEX_BITS/
// MAX_BRANCH_IF values needs the matching package constants.
package structs;

   localparam int unsigned BRU_PC_BITS        = 32;
   localparam int unsigned BRU_ROB_INDEX_BITS = 3;
   localparam int unsigned BRU_MAX_BRANCH_IF  = 2;
   localparam int unsigned BRU_RAT_ID_BITS    = $clog2(BRU_MAX_BRANCH_IF);

   // In-order resolved-branch record sent to the branch predictor.
   typedef struct packed {
      logic                          valid_jump;
      logic                          jump_taken;
      logic [BRU_PC_BITS-1:0]        jump_address;
      logic [BRU_PC_BITS-1:0]        orig_pc;
      logic                          is_comp;
      logic [BRU_ROB_INDEX_BITS-1:0] ticket;
      logic [BRU_RAT_ID_BITS-1:0]    rat_id;
   } predictor_update;

   // Per-slot lifecycle of an in-flight branch.
   typedef enum logic [1:0] {
      SlotFree     = 2'd0,
      SlotPending  = 2'd1,
      SlotResolved = 2'd2
   } slot_state_e;

endpackage

// File: rtl/bru_slot_array.sv
// Slot storage for the branch update sequencer: alloc write port, resolve
// write port, free port, a head read port and a state lookup for the slot a
// resolve targets.
module bru_slot_array
   import structs::*;
#(
   parameter int unsigned PC_BITS        = BRU_PC_BITS,
   parameter int unsigned ROB_INDEX_BITS = BRU_ROB_INDEX_BITS,
   parameter int unsigned SLOTS          = BRU_MAX_BRANCH_IF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       alloc_we,
   input  logic [$clog2(SLOTS)-1:0]   alloc_idx,
   input  logic [PC_BITS-1:0]         alloc_pc,
   input  logic                       alloc_is_comp,
   input  logic [ROB_INDEX_BITS-1:0]  alloc_ticket,
   input  logic                       res_we,
   input  logic [$clog2(SLOTS)-1:0]   res_idx,
   input  logic                       res_taken,
   input  logic [PC_BITS-1:0]         res_target,
   input  logic                       free_we,
   input  logic [$clog2(SLOTS)-1:0]   free_idx,
   input  logic [$clog2(SLOTS)-1:0]   head_idx,
   output slot_state_e                head_state,
   output logic [PC_BITS-1:0]         head_pc,
   output logic                       head_is_comp,
   output logic [ROB_INDEX_BITS-1:0]  head_ticket,
   output logic                       head_taken,
   output logic [PC_BITS-1:0]         head_target,
   output slot_state_e                res_state
);

   slot_state_e               state_q   [SLOTS];
   logic [PC_BITS-1:0]        pc_q      [SLOTS];
   logic                      is_comp_q [SLOTS];
   logic [ROB_INDEX_BITS-1:0] ticket_q  [SLOTS];
   logic                      taken_q   [SLOTS];
   logic [PC_BITS-1:0]        target_q  [SLOTS];

   assign head_state   = state_q[head_idx];
   assign head_pc      = pc_q[head_idx];
   assign head_is_comp = is_comp_q[head_idx];
   assign head_ticket  = ticket_q[head_idx];
   assign head_taken   = taken_q[head_idx];
   assign head_target  = target_q[head_idx];
   assign res_state    = state_q[res_idx];

   // Slot writes; free is last so it wins if a bypassed resolve hits head.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= '{default: SlotFree};
         pc_q      <= '{default: '0};
         is_comp_q <= '{default: 1'b0};
         ticket_q  <= '{default: '0};
         taken_q   <= '{default: 1'b0};
         target_q  <= '{default: '0};
      end else if (clear) begin
         state_q <= '{default: SlotFree};
      end else begin
         if (alloc_we) begin
            state_q[alloc_idx]   <= SlotPending;
            pc_q[alloc_idx]      <= alloc_pc;
            is_comp_q[alloc_idx] <= alloc_is_comp;
            ticket_q[alloc_idx]  <= alloc_ticket;
         end
         if (res_we) begin
            state_q[res_idx]  <= SlotResolved;
            taken_q[res_idx]  <= res_taken;
            target_q[res_idx] <= res_target;
         end
         if (free_we) begin
            state_q[free_idx] <= SlotFree;
         end
      end
   end

endmodule

// File: rtl/branch_update_sequencer.sv
// Branch update sequencer: allocates branch slots in program order, accepts
// out-of-order resolves and replays resolved branches to the predictor in
// program order, one per cycle.
// Optional macro BRU_BYPASS_EN: a resolve hitting the pending head emits in
// the same cycle from the resolve inputs instead of one cycle later.
module branch_update_sequencer
   import structs::*;
#(
   parameter int unsigned PC_BITS        = BRU_PC_BITS,
   parameter int unsigned ROB_INDEX_BITS = BRU_ROB_INDEX_BITS,
   parameter int unsigned MAX_BRANCH_IF  = BRU_MAX_BRANCH_IF
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               alloc_valid,
   output logic                               alloc_ready,
   input  logic [PC_BITS-1:0]                 alloc_pc,
   input  logic                               alloc_is_comp,
   input  logic [ROB_INDEX_BITS-1:0]          alloc_ticket,
   output logic [$clog2(MAX_BRANCH_IF)-1:0]   alloc_rat_id,
   input  logic                               resolve_valid,
   input  logic [$clog2(MAX_BRANCH_IF)-1:0]   resolve_rat_id,
   input  logic                               resolve_taken,
   input  logic [PC_BITS-1:0]                 resolve_target,
   input  logic                               flush_valid,
   output predictor_update                    pr_update,
   output logic                               resolve_err
);

   localparam int unsigned RAT_BITS = $clog2(MAX_BRANCH_IF);
   localparam int unsigned CNT_BITS = $clog2(MAX_BRANCH_IF + 1);
   localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(MAX_BRANCH_IF);

   logic [RAT_BITS-1:0]       head_q, head_d, tail_q, tail_d;
   logic [CNT_BITS-1:0]       count_q, count_d;
   logic                      err_q, err_d;

   slot_state_e               head_state, res_state;
   logic [PC_BITS-1:0]        head_pc, head_target;
   logic                      head_is_comp, head_taken;
   logic [ROB_INDEX_BITS-1:0] head_ticket;

   logic alloc_fire, res_hit, res_miss, emit_stored, emit_bypass, emit;

   // Space freed by a same-cycle pop is only visible next cycle (count_q).
   assign alloc_ready  = (count_q < CNT_FULL) && !flush_valid;
   assign alloc_fire   = alloc_valid && alloc_ready;
   assign alloc_rat_id = tail_q;

   // Emission ignores flush_valid so the flush path has no loop back here.
   assign emit_stored = (head_state == SlotResolved);
`ifdef BRU_BYPASS_EN
   assign emit_bypass = resolve_valid && (resolve_rat_id == head_q) &&
                        (head_state == SlotPending);
`else
   assign emit_bypass = 1'b0;
`endif
   assign emit = (emit_stored || emit_bypass) && !rst;

   // A bypassed resolve is consumed by the emission, not stored.
   assign res_hit  = resolve_valid && !flush_valid && (res_state == SlotPending) &&
                     !emit_bypass;
   assign res_miss = resolve_valid && !flush_valid && (res_state != SlotPending);

   assign resolve_err = err_q;

   bru_slot_array #(
      .PC_BITS        (PC_BITS),
      .ROB_INDEX_BITS (ROB_INDEX_BITS),
      .SLOTS          (MAX_BRANCH_IF)
   ) u_slots (
      .clk           (clk),
      .rst           (rst),
      .clear         (flush_valid),
      .alloc_we      (alloc_fire),
      .alloc_idx     (tail_q),
      .alloc_pc      (alloc_pc),
      .alloc_is_comp (alloc_is_comp),
      .alloc_ticket  (alloc_ticket),
      .res_we        (res_hit),
      .res_idx       (resolve_rat_id),
      .res_taken     (resolve_taken),
      .res_target    (resolve_target),
      .free_we       (emit),
      .free_idx      (head_q),
      .head_idx      (head_q),
      .head_state    (head_state),
      .head_pc       (head_pc),
      .head_is_comp  (head_is_comp),
      .head_ticket   (head_ticket),
      .head_taken    (head_taken),
      .head_target   (head_target),
      .res_state     (res_state)
   );

   // Predictor update record; all fields zero when nothing is emitted.
   always_comb begin
      pr_update = '0;
      if (emit) begin
         pr_update.valid_jump   = 1'b1;
         pr_update.jump_taken   = emit_bypass ? resolve_taken : head_taken;
         pr_update.jump_address = emit_bypass ? resolve_target : head_target;
         pr_update.orig_pc      = head_pc;
         pr_update.is_comp      = head_is_comp;
         pr_update.ticket       = head_ticket;
         pr_update.rat_id       = head_q;
      end
   end

   // Occupancy pointers, count and sticky resolve error.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      err_d   = err_q | res_miss;
      if (flush_valid) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (alloc_fire) tail_d = tail_q + RAT_BITS'(1);
         if (emit)       head_d = head_q + RAT_BITS'(1);
         count_d = count_q + CNT_BITS'(alloc_fire) - CNT_BITS'(emit);
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_branch_update_sequencer.sv
// Directed bench for branch_update_sequencer: a table of single-cycle vectors
// followed by hand-written flush, reset and sticky-error sequences.
module tb_branch_update_sequencer;
   import structs::*;

   logic            clk = 1'b0;
   logic            rst;
   logic            alloc_valid, alloc_ready, alloc_is_comp;
   logic [31:0]     alloc_pc;
   logic [2:0]      alloc_ticket;
   logic            alloc_rat_id;
   logic            resolve_valid, resolve_rat_id, resolve_taken;
   logic [31:0]     resolve_target;
   logic            flush_valid;
   predictor_update pr_update;
   logic            resolve_err;

   int n_cmp;
   int n_fail;

   always #5 clk = ~clk;

   branch_update_sequencer dut (
      .clk            (clk),
      .rst            (rst),
      .alloc_valid    (alloc_valid),
      .alloc_ready    (alloc_ready),
      .alloc_pc       (alloc_pc),
      .alloc_is_comp  (alloc_is_comp),
      .alloc_ticket   (alloc_ticket),
      .alloc_rat_id   (alloc_rat_id),
      .resolve_valid  (resolve_valid),
      .resolve_rat_id (resolve_rat_id),
      .resolve_taken  (resolve_taken),
      .resolve_target (resolve_target),
      .flush_valid    (flush_valid),
      .pr_update      (pr_update),
      .resolve_err    (resolve_err)
   );

   typedef struct {
      string           name;
      logic            av;
      logic [31:0]     apc;
      logic            ac;
      logic [2:0]      at;
      logic            rv;
      logic            rid;
      logic            rt;
      logic [31:0]     rtg;
      logic            fl;
      logic            e_ready;
      logic            e_arid;
      predictor_update e_pr;
      logic            e_err;
   } vec_t;

   vec_t tbl[$];
   localparam predictor_update NOPR = '0;

   function automatic predictor_update pr(input logic tk, input logic [31:0] ja,
                                          input logic [31:0] opc, input logic ic,
                                          input logic [2:0] tkt, input logic rid);
      predictor_update p;
      p              = '0;
      p.valid_jump   = 1'b1;
      p.jump_taken   = tk;
      p.jump_address = ja;
      p.orig_pc      = opc;
      p.is_comp      = ic;
      p.ticket       = tkt;
      p.rat_id       = rid;
      return p;
   endfunction

   function automatic vec_t mk(input string n, input logic av, input logic [31:0] apc,
                               input logic ac, input logic [2:0] at, input logic rv,
                               input logic rid, input logic rt, input logic [31:0] rtg,
                               input logic fl, input logic er, input logic ea,
                               input predictor_update ep);
      vec_t v;
      v.name = n; v.av = av; v.apc = apc; v.ac = ac; v.at = at;
      v.rv = rv; v.rid = rid; v.rt = rt; v.rtg = rtg; v.fl = fl;
      v.e_ready = er; v.e_arid = ea; v.e_pr = ep; v.e_err = 1'b0;
      return v;
   endfunction

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic chk_pr(input string name, input predictor_update act,
                         input predictor_update exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic av, input logic [31:0] apc, input logic ac,
                         input logic [2:0] at, input logic rv, input logic rid,
                         input logic rt, input logic [31:0] rtg, input logic fl);
      alloc_valid = av; alloc_pc = apc; alloc_is_comp = ac; alloc_ticket = at;
      resolve_valid = rv; resolve_rat_id = rid; resolve_taken = rt;
      resolve_target = rtg; flush_valid = fl;
   endtask

   task automatic idle();
      set_in(1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      rst    = 1'b1;
      idle();

      // Allocation, out-of-order resolve, full handling and in-order replay.
      tbl.push_back(mk("idle",  0, 32'h0,   0, 3'd0, 0, 0, 0, 32'h0,   0, 1, 0, NOPR));
      tbl.push_back(mk("alloc0", 1, 32'h100, 0, 3'd1, 0, 0, 0, 32'h0,   0, 1, 0, NOPR));
      tbl.push_back(mk("alloc1", 1, 32'h104, 0, 3'd2, 0, 0, 0, 32'h0,   0, 1, 1, NOPR));
      tbl.push_back(mk("full_res1", 1, 32'h999, 0, 3'd7, 1, 1, 1, 32'h200, 0, 0, 0, NOPR));
`ifdef BRU_BYPASS_EN
      tbl.push_back(mk("res0_byp", 0, 32'h0, 0, 3'd0, 1, 0, 0, 32'h108, 0, 0, 0,
                       pr(0, 32'h108, 32'h100, 0, 3'd1, 0)));
`else
      tbl.push_back(mk("res0_wait", 0, 32'h0, 0, 3'd0, 1, 0, 0, 32'h108, 0, 0, 0, NOPR));
      tbl.push_back(mk("emit0", 0, 32'h0, 0, 3'd0, 0, 0, 0, 32'h0, 0, 0, 0,
                       pr(0, 32'h108, 32'h100, 0, 3'd1, 0)));
`endif
      tbl.push_back(mk("emit1", 0, 32'h0, 0, 3'd0, 0, 0, 0, 32'h0, 0, 1, 0,
                       pr(1, 32'h200, 32'h104, 0, 3'd2, 1)));
      tbl.push_back(mk("drained", 0, 32'h0, 0, 3'd0, 0, 0, 0, 32'h0, 0, 1, 0, NOPR));
      // Compressed branch, then alloc concurrent with emit, then taken 0x300.
      tbl.push_back(mk("alloc_comp", 1, 32'h80, 1, 3'd5, 0, 0, 0, 32'h0, 0, 1, 0, NOPR));
`ifdef BRU_BYPASS_EN
      tbl.push_back(mk("res_comp", 0, 32'h0, 0, 3'd0, 1, 0, 0, 32'h82, 0, 1, 1,
                       pr(0, 32'h82, 32'h80, 1, 3'd5, 0)));
      tbl.push_back(mk("alloc40", 1, 32'h40, 0, 3'd6, 0, 0, 0, 32'h0, 0, 1, 1, NOPR));
      tbl.push_back(mk("res_head_300", 0, 32'h0, 0, 3'd0, 1, 1, 1, 32'h300, 0, 1, 0,
                       pr(1, 32'h300, 32'h40, 0, 3'd6, 1)));
`else
      tbl.push_back(mk("res_comp", 0, 32'h0, 0, 3'd0, 1, 0, 0, 32'h82, 0, 1, 1, NOPR));
      tbl.push_back(mk("emit_comp_alloc", 1, 32'h40, 0, 3'd6, 0, 0, 0, 32'h0, 0, 1, 1,
                       pr(0, 32'h82, 32'h80, 1, 3'd5, 0)));
      tbl.push_back(mk("res_head_300", 0, 32'h0, 0, 3'd0, 1, 1, 1, 32'h300, 0, 1, 0, NOPR));
      tbl.push_back(mk("emit_300", 0, 32'h0, 0, 3'd0, 0, 0, 0, 32'h0, 0, 1, 0,
                       pr(1, 32'h300, 32'h40, 0, 3'd6, 1)));
`endif
      tbl.push_back(mk("final_idle", 0, 32'h0, 0, 3'd0, 0, 0, 0, 32'h0, 0, 1, 0, NOPR));

      // Reset behaviour.
      repeat (2) @(posedge clk);
      #1;
      chk_pr("reset.pr_update", pr_update, NOPR);
      chk1("reset.resolve_err", resolve_err, 1'b0);
      rst = 1'b0;

      foreach (tbl[i]) begin
         set_in(tbl[i].av, tbl[i].apc, tbl[i].ac, tbl[i].at, tbl[i].rv, tbl[i].rid,
                tbl[i].rt, tbl[i].rtg, tbl[i].fl);
         #1;
         chk1({tbl[i].name, ".alloc_ready"}, alloc_ready, tbl[i].e_ready);
         chk1({tbl[i].name, ".alloc_rat_id"}, alloc_rat_id, tbl[i].e_arid);
         chk_pr({tbl[i].name, ".pr_update"}, pr_update, tbl[i].e_pr);
         chk1({tbl[i].name, ".resolve_err"}, resolve_err, tbl[i].e_err);
         tick();
      end

      // Flush with two pending plus concurrent alloc and resolve.
      set_in(1, 32'h10, 0, 3'd0, 0, 0, 0, 32'h0, 0);
      tick();
      set_in(1, 32'h14, 0, 3'd1, 0, 0, 0, 32'h0, 0);
      tick();
      set_in(1, 32'h18, 0, 3'd2, 1, 1, 1, 32'h20, 1);
      #1;
      chk1("flush.alloc_ready", alloc_ready, 1'b0);
      chk_pr("flush.pr_update", pr_update, NOPR);
      tick();
      idle();
      #1;
      chk_pr("post_flush.pr_update", pr_update, NOPR);
      chk1("post_flush.alloc_ready", alloc_ready, 1'b1);
      chk1("post_flush.alloc_rat_id", alloc_rat_id, 1'b0);
      chk1("post_flush.resolve_err", resolve_err, 1'b0);
      // Slot 0 must be free: the alloc in the flush cycle was dropped.
      set_in(0, 32'h0, 0, 3'd0, 1, 0, 1, 32'h24, 0);
      #1;
      chk_pr("dropped_alloc.pr_update", pr_update, NOPR);
      tick();
      idle();
      #1;
      chk1("dropped_alloc.resolve_err", resolve_err, 1'b1);
      // Count restarted from zero: exactly two allocations fit.
      set_in(1, 32'h30, 0, 3'd3, 0, 0, 0, 32'h0, 0);
      #1;
      chk1("refill0.alloc_rat_id", alloc_rat_id, 1'b0);
      tick();
      set_in(1, 32'h34, 0, 3'd4, 0, 0, 0, 32'h0, 0);
      #1;
      chk1("refill1.alloc_rat_id", alloc_rat_id, 1'b1);
      tick();
      idle();
      #1;
      chk1("refill.full", alloc_ready, 1'b0);
      for (int k = 0; k < 2; k++) begin
         tick();
         chk1("err.sticky_idle", resolve_err, 1'b1);
      end

      // Reset mid-operation discards in-flight entries without emitting.
      set_in(0, 32'h0, 0, 3'd0, 1, 1, 1, 32'h50, 0);
      tick();
      idle();
      #1;
      chk_pr("rst_mid.head_waits", pr_update, NOPR);
      rst = 1'b1;
      set_in(0, 32'h0, 0, 3'd0, 1, 0, 0, 32'h54, 0);
      #1;
      chk_pr("rst_mid.during", pr_update, NOPR);
      tick();
      rst = 1'b0;
      idle();
      #1;
      chk_pr("rst_mid.after", pr_update, NOPR);
      chk1("rst_mid.alloc_ready", alloc_ready, 1'b1);
      chk1("rst_mid.alloc_rat_id", alloc_rat_id, 1'b0);
      chk1("rst_mid.resolve_err", resolve_err, 1'b0);
      tick();
      chk_pr("rst_mid.no_stale", pr_update, NOPR);

      // Resolve of a free slot sets a sticky error that survives flush.
      set_in(0, 32'h0, 0, 3'd0, 1, 1, 1, 32'h60, 0);
      tick();
      idle();
      #1;
      chk1("err.free_resolve", resolve_err, 1'b1);
      set_in(0, 32'h0, 0, 3'd0, 0, 0, 0, 32'h0, 1);
      tick();
      idle();
      #1;
      chk1("err.sticky_flush", resolve_err, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk1("err.cleared_by_rst", resolve_err, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
